// File: rtl/aes128_decrypt.sv
// aes128_decrypt -- iterative AES-128 inverse cipher, one round per clock.
//
// The cipher key is expanded once (one round key per clock) into an
// 11-entry round-key store. Each block is then decrypted in 10 round cycles,
// consuming the round keys from rk10 down to rk0.
//
// Ports:
//   clk, reset_n        clock; synchronous active-low reset
//   key_load, key       1-cycle strobe starting key expansion from key
//   key_ready           round keys rk0..rk10 valid
//   in_valid, in_ready  ciphertext handshake
//   ciphertext          128-bit block, [127:120] = byte 0 = state[0][0]
//   out_valid,out_ready plaintext handshake
//   plaintext           128-bit result, same byte order
//   busy                key expansion or decryption in progress
//   key_clear           (only with AES_DEC_KEY_ZEROIZE_EN) wipes keys/state
//
// Optional feature macro: AES_DEC_KEY_ZEROIZE_EN.
module aes128_decrypt (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_load,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
`ifdef AES_DEC_KEY_ZEROIZE_EN
  input  logic         key_clear,
`endif
  output logic         busy
);

  // Byte i of each table sits at bits [2047-8*i -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  typedef enum logic [2:0] {IDLE, KEXP, ROUND, FINAL, DONE} state_t;

  state_t       state_q;
  logic [127:0] rk_q [11];
  logic [3:0]   kcnt_q;
  logic [3:0]   rnd_q;
  logic [127:0] s_q;
  logic [127:0] pt_q;
  logic         key_ready_q;
  logic         out_valid_q;

  logic [127:0] isb_d;
  logic [127:0] round_d;
  logic [127:0] final_d;
  logic [127:0] prev_rk;
  logic [31:0]  temp_w, n0, n1, n2, n3;
  logic [127:0] rk_nxt_d;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[{8'd255 - b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] isb(input logic [7:0] b);
    return INV_SBOX[{8'd255 - b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (enough for 09/0b/0d/0e).
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
           (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = v[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++)
      o[127 - 8*i -: 8] = isb(v[127 - 8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = v[127 - 32*c -: 8];
      a1 = v[119 - 32*c -: 8];
      a2 = v[111 - 32*c -: 8];
      a3 = v[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[119 - 32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[111 - 32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[103 - 32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    case (k)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    isb_d    = inv_sub_bytes(inv_shift_rows(s_q));
    round_d  = inv_mix_columns(isb_d ^ rk_q[rnd_q]);
    final_d  = isb_d ^ rk_q[0];
    // Key schedule step: SubWord(RotWord(w3)) ^ rcon, then the 4-word XOR chain.
    prev_rk  = rk_q[kcnt_q - 4'd1];
    temp_w   = {sb(prev_rk[23:16]), sb(prev_rk[15:8]), sb(prev_rk[7:0]), sb(prev_rk[31:24])}
               ^ {rcon(kcnt_q), 24'h000000};
    n0       = prev_rk[127:96] ^ temp_w;
    n1       = prev_rk[95:64]  ^ n0;
    n2       = prev_rk[63:32]  ^ n1;
    n3       = prev_rk[31:0]   ^ n2;
    rk_nxt_d = {n0, n1, n2, n3};
  end

  assign in_ready  = (state_q == IDLE) && key_ready_q && !key_load;
  assign busy      = (state_q == KEXP) || (state_q == ROUND) || (state_q == FINAL);
  assign key_ready = key_ready_q;
  assign out_valid = out_valid_q;
  assign plaintext = pt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      kcnt_q      <= '0;
      rnd_q       <= '0;
      s_q         <= '0;
      pt_q        <= '0;
      key_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < 11; i++) rk_q[i] <= '0;
`ifdef AES_DEC_KEY_ZEROIZE_EN
    end else if (key_clear) begin
      state_q     <= IDLE;
      kcnt_q      <= '0;
      rnd_q       <= '0;
      s_q         <= '0;
      pt_q        <= '0;
      key_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < 11; i++) rk_q[i] <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (key_load) begin
            rk_q[0]     <= key;
            kcnt_q      <= 4'd1;
            key_ready_q <= 1'b0;
            state_q     <= KEXP;
          end else if (in_valid && in_ready) begin
            s_q     <= ciphertext ^ rk_q[10];
            rnd_q   <= 4'd9;
            state_q <= ROUND;
          end
        end
        KEXP: begin
          rk_q[kcnt_q] <= rk_nxt_d;
          if (kcnt_q == 4'd10) begin
            kcnt_q      <= '0;
            key_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            kcnt_q <= kcnt_q + 4'd1;
          end
        end
        ROUND: begin
          s_q   <= round_d;
          rnd_q <= rnd_q - 4'd1;
          if (rnd_q == 4'd1) state_q <= FINAL;
        end
        FINAL: begin
          pt_q        <= final_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt.sv
// tb_aes128_decrypt -- self-checking bench for aes128_decrypt.
// Known-answer vectors are applied from a table; expected plaintexts enter a
// scoreboard queue on each input handshake and are compared on each output
// handshake. Hand-written sequences cover backpressure, key_load while busy
// and reset in the middle of a block.
module tb_aes128_decrypt;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         key_load;
  logic [127:0] key;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;
`ifdef AES_DEC_KEY_ZEROIZE_EN
  logic         key_clear = 1'b0;
`endif

  always #5 clk = ~clk;

  aes128_decrypt dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_load   (key_load),
    .key        (key),
    .key_ready  (key_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
`ifdef AES_DEC_KEY_ZEROIZE_EN
    .key_clear  (key_clear),
`endif
    .busy       (busy)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] K_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;

  int           total = 0;
  int           bad   = 0;
  logic [127:0] exp_q [$];
  logic [127:0] exp_cur;
  vec_t         vecs [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (in_valid && in_ready) exp_q.push_back(exp_cur);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h, expected no output", plaintext);
        end else begin
          chk("plaintext", plaintext, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    int n;
    key_load = 1'b1;
    key      = k;
    tick();
    key_load = 1'b0;
    chk("key_ready_drop", 128'(key_ready), 128'(0));
    chk("busy_kexp", 128'(busy), 128'(1));
    n = 0;
    while (!key_ready && n < 20) begin
      tick();
      n++;
    end
    chk("kexp_latency", 128'(n), 128'(10));
  endtask

  // Returns #1 after the accepting edge.
  task automatic start_block(input logic [127:0] ct, input logic [127:0] pt);
    int   n;
    logic acc;
    in_valid   = 1'b1;
    ciphertext = ct;
    exp_cur    = pt;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) fail_now("accept_timeout");
  endtask

  task automatic wait_out(input bit check_lat);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) fail_now("out_valid_timeout");
    else if (check_lat) chk("dec_latency", 128'(n), 128'(10));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (out_valid && n < 50) begin
      tick();
      n++;
    end
    if (out_valid) fail_now("drain_timeout");
  endtask

  initial begin
    vecs[0] = '{key: K_B, ct: 128'h3925841d02dc09fbdc118597196a0b32,
                pt: 128'h3243f6a8885a308d313198a2e0370734};
    vecs[1] = '{key: K_C1, ct: CT_C1, pt: PT_C1};
    vecs[2] = '{key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, pt: 128'h0};
    vecs[3] = '{key: K_B, ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                pt: 128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[4] = '{key: K_B, ct: 128'hf5d3d58503b9699de785895a96fdbaaf,
                pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51};

    reset_n    = 1'b0;
    key_load   = 1'b0;
    key        = '0;
    in_valid   = 1'b0;
    ciphertext = '0;
    out_ready  = 1'b1;
    exp_cur    = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_key_ready", 128'(key_ready), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_plaintext", plaintext, 128'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Known-answer table.
    for (int i = 0; i < 5; i++) begin
      load_key(vecs[i].key);
      if (i == 0) chk("rk10", dut.rk_q[10], RK10_B);
      start_block(vecs[i].ct, vecs[i].pt);
      wait_out(1'b1);
      drain();
    end

    // Output backpressure with a second block waiting.
    load_key(K_B);
    out_ready = 1'b0;
    start_block(vecs[3].ct, vecs[3].pt);
    wait_out(1'b1);
    in_valid   = 1'b1;
    ciphertext = vecs[0].ct;
    exp_cur    = vecs[0].pt;
    repeat (20) begin
      @(negedge clk);
      chk("bp_plaintext", plaintext, vecs[3].pt);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_second_accept", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    wait_out(1'b1);
    drain();

    // key_load while decrypting is ignored.
    load_key(K_C1);
    start_block(CT_C1, PT_C1);
    repeat (3) tick();
    key_load = 1'b1;
    key      = '0;
    tick();
    key_load = 1'b0;
    chk("kl_busy_key_ready", 128'(key_ready), 128'(1));
    wait_out(1'b0);
    drain();
    chk("kl_after_key_ready", 128'(key_ready), 128'(1));
    start_block(CT_C1, PT_C1);
    wait_out(1'b1);
    drain();

    // Reset asserted so that it is sampled at T5.
    start_block(CT_C1, PT_C1);
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    chk("mr_out_valid", 128'(out_valid), 128'(0));
    chk("mr_key_ready", 128'(key_ready), 128'(0));
    chk("mr_in_ready", 128'(in_ready), 128'(0));
    chk("mr_busy", 128'(busy), 128'(0));
    exp_q.delete();
    tick();
    reset_n    = 1'b1;
    in_valid   = 1'b1;
    ciphertext = CT_C1;
    exp_cur    = PT_C1;
    repeat (15) begin
      @(negedge clk);
      chk("mr_no_accept", 128'(in_ready), 128'(0));
      tick();
    end
    load_key(K_C1);
    start_block(CT_C1, PT_C1);
    wait_out(1'b1);
    drain();

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/aes128_decrypt.md
Name: aes128_decrypt

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 §5.3): one round per clock, 10 round cycles per 128-bit block.
- Sits beside the iterative encryptor as its receive-side counterpart.
- Expands the cipher key once into an 11-entry round-key store, then consumes round keys in reverse order (rk10 to rk0).
- Valid/ready handshake on both ciphertext input and plaintext output.

Parameters:
- None. AES-128 only; Nr = 10 fixed.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset: synchronous, active-low, sampled on rising clk
- key_load  in  1  1-cycle strobe; start key expansion from key
- key  in  128  cipher key; bits [127:120] = key byte 0
- key_ready  out  1  round keys rk0..rk10 valid
- in_valid  in  1  ciphertext valid
- in_ready  out  1  block accepted when in_valid && in_ready
- ciphertext  in  128  FIPS-197 byte order; [127:120] = byte 0 = state[0][0], column-major
- out_valid  out  1  plaintext valid
- out_ready  in  1  sink accepts plaintext
- plaintext  out  128  result, same byte order
- busy  out  1  key expansion or decryption in progress

Behaviour:
- Reset values:
  - Outputs: key_ready=0, in_ready=0, out_valid=0, busy=0, plaintext=0.
  - FSM = IDLE; round counter = 0.
  - Round-key store is cleared to 0. A key must be reloaded after reset.
- FSM states: IDLE, KEXP, ROUND, FINAL, DONE.
- IDLE:
  - key_load=1 at edge E0 -> rk0 <= key, kcnt <= 1, go to KEXP. key_ready drops to 0 at E0.
  - Otherwise, on in_valid && in_ready -> s <= ciphertext ^ rk10, rnd <= 9, go to ROUND.
  - key_load takes priority over in_valid in the same cycle.
- KEXP:
  - One round key per edge: rk[k] = f(rk[k-1], rcon[k]) using RotWord, SubWord (forward S-box) and the standard 4-word XOR chain.
  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - rk10 is written at edge E10; key_ready=1 from E10. Return to IDLE.
- ROUND (rnd = 9 down to 1):
  - s <= InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ rk[rnd]); rnd <= rnd-1.
  - When rnd=1, go to FINAL.
  - InvMixColumns coefficients: 0e,0b,0d,09 in GF(2^8), polynomial 0x11b.
- FINAL:
  - plaintext <= InvSubBytes(InvShiftRows(s)) ^ rk0; out_valid <= 1; go to DONE.
- DONE:
  - Hold plaintext and out_valid stable until out_valid && out_ready.
  - Then out_valid <= 0 and go to IDLE.
- Latency: out_valid rises on the 10th rising edge after the accepting edge.
  - Accept edge T0: initial AddRoundKey.
  - T1..T9: main rounds.
  - T10: final round.
- in_ready = (state==IDLE) && key_ready && !key_load. It is never high while out_valid=1.
  - Minimum throughput: 1 block per 12 cycles with out_ready tied high.
- busy = (state==KEXP || state==ROUND || state==FINAL).
- key_load outside IDLE is ignored. The in-flight block always completes with the keys it started with.
- in_valid while key_ready=0 is not accepted; the source must hold its data until the handshake completes.
- reset_n low mid-operation: the in-flight block is discarded, all outputs go to their reset values, and the key is lost.
- Arithmetic: XOR and GF(2^8) only; no carries.
- Inverse and forward S-boxes are 256-entry combinational tables:
  - 16 inverse S-box lookups for the state.
  - 4 forward S-box lookups for key expansion.

Optional Feature:
- Macro: AES_DEC_KEY_ZEROIZE_EN.
- Defined:
  - Adds input port key_clear (1 bit).
  - key_clear=1 at a rising edge, in any state:
    - All rk0..rk10, s and plaintext are set to 0.
    - key_ready=0, out_valid=0; FSM goes to IDLE; any in-flight block is dropped.
  - key_clear has priority over key_load.
- Not defined:
  - The port is absent.
  - Round keys persist until reset or the next key_load.

Test Plan:
- Key expansion:
  - Stimulus: key_load with key=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: key_ready rises exactly 10 edges after key_load is sampled; internal rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 Appendix B vector:
  - Stimulus: same key; ciphertext=3925841d02dc09fbdc118597196a0b32.
  - Required: plaintext=3243f6a8885a308d313198a2e0370734, out_valid asserted 10 edges after accept.
- FIPS-197 Appendix C.1 vector:
  - Stimulus: key=000102030405060708090a0b0c0d0e0f; ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: plaintext=00112233445566778899aabbccddeeff.
- Output backpressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid, with a second in_valid held high.
  - Required: plaintext stable, in_ready=0 throughout; second block accepted on the cycle after out_ready=1.
- key_load during decryption:
  - Stimulus: pulse key_load=1 with key=0 during ROUND (decrypting the C.1 ciphertext).
  - Required: key_load ignored; plaintext still 00112233445566778899aabbccddeeff; key_ready stays 1.
- Reset mid-round:
  - Stimulus: reset_n=0 at T5.
  - Required: out_valid=0, key_ready=0, in_ready=0 next cycle; a subsequent in_valid is not accepted until a key is reloaded.
